// File: rtl/rot_decoder_if.sv
// Bundles the scan request, the sample-RAM read port and the (theta, data) output stream
// of rot_decoder. The master modport is the decoder side.
interface rot_decoder_if #(
    parameter int ANG_W  = 16,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              start;
    logic [ANG_W-1:0]  ref_angle;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   len;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_data;

    logic [ANG_W-1:0]  theta;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic              out_ready;

    logic              busy;
    logic              done;

    modport master (
        input  start, ref_angle, base_addr, len, mem_data, out_ready,
        output mem_addr, mem_rd, theta, data_out, out_valid, busy, done
    );

    modport slave (
        output start, ref_angle, base_addr, len, mem_data, out_ready,
        input  mem_addr, mem_rd, theta, data_out, out_valid, busy, done
    );
endinterface

// File: rtl/rot_decoder.sv
// Scans sample-RAM bins and rebuilds theta = ref + signed(addr) for each entry, streaming (theta, data).
// Optional macro ROT_DEC_SKIP_ZERO_EN drops empty (zero) bins instead of emitting them.
module rot_decoder #(
    parameter int ANG_W  = 16,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input logic           clk,
    input logic           rst,
    rot_decoder_if.master bus
);

    typedef enum logic [2:0] {IDLE, READ, CAPT, OUT, FIN} state_t;

    state_t            state, state_d;
    logic [ANG_W-1:0]  ref_q;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W:0]   remaining;
    logic [ANG_W-1:0]  theta_q;
    logic [DATA_W-1:0] data_q;
    logic              advance;
    logic              last_entry;
    logic              skip;

    // The RAM address is the low bits of (theta - ref), so it is a two's complement offset.
    function automatic logic [ANG_W-1:0] abs_angle(input logic [ANG_W-1:0] r,
                                                   input logic signed [ADDR_W-1:0] off);
        logic signed [ANG_W-1:0] off_ext;
        off_ext = {{(ANG_W-ADDR_W){off[ADDR_W-1]}}, off};
        return r + ANG_W'(off_ext);
    endfunction

    assign last_entry = (remaining == (ADDR_W+1)'(1));

`ifdef ROT_DEC_SKIP_ZERO_EN
    assign skip = (state == CAPT) && (bus.mem_data == '0);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        advance = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_d = (bus.len == '0) ? FIN : READ;
            end
            READ: state_d = CAPT;
            CAPT: begin
                if (skip) begin
                    advance = 1'b1;
                    state_d = last_entry ? FIN : READ;
                end else begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    advance = 1'b1;
                    state_d = last_entry ? FIN : READ;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q     <= '0;
            cur_addr  <= '0;
            last_addr <= '0;
            remaining <= '0;
            theta_q   <= '0;
            data_q    <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                ref_q     <= bus.ref_angle;
                cur_addr  <= bus.base_addr;
                remaining <= bus.len;
            end
            if (state == READ) last_addr <= cur_addr;
            // RAM data arrives the cycle after the read strobe.
            if (state == CAPT) begin
                data_q  <= bus.mem_data;
                theta_q <= abs_angle(ref_q, cur_addr);
            end
            if (advance) begin
                remaining <= remaining - (ADDR_W+1)'(1);
                cur_addr  <= cur_addr + ADDR_W'(1);
            end
        end
    end

    assign bus.mem_addr  = (state == READ) ? cur_addr : last_addr;
    assign bus.mem_rd    = (state == READ);
    assign bus.theta     = theta_q;
    assign bus.data_out  = data_q;
    assign bus.out_valid = (state == OUT);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FIN);

endmodule

// File: tb/tb_rot_decoder.sv
// Bench for rot_decoder: vector table, corner-case sequences and random scans against a list model.
module tb_rot_decoder;
    localparam int ANG_W  = 16;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rot_decoder_if #(.ANG_W(ANG_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    rot_decoder #(.ANG_W(ANG_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] ram [256];
    logic [15:0] got_th [$];
    logic [31:0] got_d  [$];
    logic [7:0]  got_a  [$];
    int done_cnt = 0;
    int n_pass   = 0;
    int n_total  = 0;

    // RAM responder and event monitors
    always @(posedge clk) begin
        if (bus.mem_rd) begin
            bus.mem_data <= ram[bus.mem_addr];
            got_a.push_back(bus.mem_addr);
        end
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic [15:0] r;
        logic [7:0]  b;
        logic [8:0]  n;
        int          rdy;
        logic [15:0] th0;
        logic [31:0] d0;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] model_theta(input int r, input int a);
        int off;
        off = (a >= 128) ? a - 256 : a;
        return 16'((r + off + 65536) % 65536);
    endfunction

    task automatic clear_q();
        got_th.delete();
        got_d.delete();
        got_a.delete();
    endtask

    task automatic start_scan(input logic [15:0] r, input logic [7:0] b, input logic [8:0] n);
        bus.ref_angle = r;
        bus.base_addr = b;
        bus.len       = n;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    // Runs until done is seen; records each handshake. Returns at the negedge where done=1.
    task automatic collect(input int rdy_pct, output bit finished);
        finished = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
            if (bus.out_valid && bus.out_ready) begin
                got_th.push_back(bus.theta);
                got_d.push_back(bus.data_out);
            end
            if (bus.done) begin
                finished = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (bus.out_valid) seen = 1'b1;
            else @(negedge clk);
        end
        check({name, ".valid_seen"}, 64'(seen), 64'(1));
    endtask

    task automatic do_scan(input string name, input logic [15:0] r, input logic [7:0] b,
                           input logic [8:0] n, input int rdy_pct, input bit chk0,
                           input logic [15:0] th0, input logic [31:0] d0);
        logic [15:0] exp_th [$];
        logic [31:0] exp_d  [$];
        logic [7:0]  exp_a  [$];
        bit fin;
        int dc;
        for (int i = 0; i < int'(n); i++) begin
            int a;
            a = (int'(b) + i) % 256;
            exp_a.push_back(8'(a));
`ifdef ROT_DEC_SKIP_ZERO_EN
            if (ram[a] == 32'd0) continue;
`endif
            exp_th.push_back(model_theta(int'(r), a));
            exp_d.push_back(ram[a]);
        end
        clear_q();
        dc = done_cnt;
        start_scan(r, b, n);
        collect(rdy_pct, fin);
        check({name, ".finished"}, 64'(fin), 64'(1));
        @(negedge clk);
        check({name, ".count"}, 64'(got_th.size()), 64'(exp_th.size()));
        for (int i = 0; i < exp_th.size(); i++) begin
            if (i < got_th.size()) begin
                check($sformatf("%s.theta[%0d]", name, i), 64'(got_th[i]), 64'(exp_th[i]));
                check($sformatf("%s.data[%0d]", name, i), 64'(got_d[i]), 64'(exp_d[i]));
            end
        end
        check({name, ".reads"}, 64'(got_a.size()), 64'(exp_a.size()));
        for (int i = 0; i < exp_a.size(); i++) begin
            if (i < got_a.size())
                check($sformatf("%s.addr[%0d]", name, i), 64'(got_a[i]), 64'(exp_a[i]));
        end
        check({name, ".done_pulses"}, 64'(done_cnt - dc), 64'(1));
        check({name, ".idle_after"}, 64'(bus.busy), 64'(0));
        if (chk0 && got_th.size() > 0) begin
            check({name, ".first_theta"}, 64'(got_th[0]), 64'(th0));
            check({name, ".first_data"}, 64'(got_d[0]), 64'(d0));
        end
    endtask

    initial begin
        vec_t vecs [7];
        bit   fin;
        int   dc;
        logic [15:0] th_hold;
        logic [31:0] d_hold;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.ref_angle = '0;
        bus.base_addr = '0;
        bus.len = '0;
        bus.out_ready = 1'b0;
        bus.mem_data = '0;
        for (int i = 0; i < 256; i++) ram[i] = $urandom | 32'h1;
        ram[8'h02] = 32'd1234;
        ram[8'h03] = 32'd5678;
        ram[8'hFB] = 32'd1;
        ram[8'hFC] = 32'd2;
        ram[8'hFD] = 32'd3;
        ram[8'hFE] = 32'd4;
        ram[8'hFF] = 32'h0000_AAAA;
        ram[8'h00] = 32'h0000_BBBB;
        ram[8'h80] = 32'h8080_8080;
        ram[8'h10] = 32'd7;
        ram[8'h11] = 32'd0;
        ram[8'h12] = 32'd9;

        repeat (3) @(negedge clk);
        check("reset.theta", 64'(bus.theta), 64'(0));
        check("reset.data_out", 64'(bus.data_out), 64'(0));
        check("reset.out_valid", 64'(bus.out_valid), 64'(0));
        check("reset.busy", 64'(bus.busy), 64'(0));
        check("reset.done", 64'(bus.done), 64'(0));
        check("reset.mem_rd", 64'(bus.mem_rd), 64'(0));
        check("reset.mem_addr", 64'(bus.mem_addr), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        vecs[0] = '{16'd45,    8'h02, 9'd2,   100, 16'd47,     32'd1234};
        vecs[1] = '{16'd45,    8'hFB, 9'd4,   100, 16'd40,     32'd1};
        vecs[2] = '{16'hFFFE,  8'h03, 9'd1,   100, 16'h0001,   32'd5678};
        vecs[3] = '{16'h0100,  8'hFF, 9'd2,   100, 16'h00FF,   32'h0000_AAAA};
        vecs[4] = '{16'd45,    8'h00, 9'd0,   100, 16'd0,      32'd0};
        vecs[5] = '{16'd1000,  8'h80, 9'd256, 70,  16'd872,    32'h8080_8080};
        vecs[6] = '{16'd500,   8'h10, 9'd3,   100, 16'd516,    32'd7};
        for (int v = 0; v < 7; v++)
            do_scan($sformatf("vec%0d", v), vecs[v].r, vecs[v].b, vecs[v].n, vecs[v].rdy,
                    1'b1, vecs[v].th0, vecs[v].d0);

        // Start-to-output latency
        clear_q();
        bus.out_ready = 1'b1;
        start_scan(16'd45, 8'h02, 9'd2);
        check("lat.mem_rd_k1", 64'(bus.mem_rd), 64'(1));
        check("lat.mem_addr_k1", 64'(bus.mem_addr), 64'(2));
        check("lat.busy_k1", 64'(bus.busy), 64'(1));
        @(negedge clk);
        check("lat.mem_rd_k2", 64'(bus.mem_rd), 64'(0));
        check("lat.mem_addr_hold", 64'(bus.mem_addr), 64'(2));
        @(negedge clk);
        check("lat.valid_k3", 64'(bus.out_valid), 64'(1));
        check("lat.theta_k3", 64'(bus.theta), 64'(47));
        collect(100, fin);
        check("lat.finished", 64'(fin), 64'(1));
        @(negedge clk);

        // Backpressure on the first entry
        clear_q();
        bus.out_ready = 1'b0;
        start_scan(16'd45, 8'h02, 9'd2);
        wait_valid("bp");
        th_hold = bus.theta;
        d_hold  = bus.data_out;
        check("bp.theta", 64'(th_hold), 64'(47));
        check("bp.data", 64'(d_hold), 64'(1234));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("bp.valid_held[%0d]", c), 64'(bus.out_valid), 64'(1));
            check($sformatf("bp.theta_stable[%0d]", c), 64'(bus.theta), 64'(th_hold));
            check($sformatf("bp.data_stable[%0d]", c), 64'(bus.data_out), 64'(d_hold));
        end
        check("bp.no_extra_reads", 64'(got_a.size()), 64'(1));
        collect(100, fin);
        check("bp.finished", 64'(fin), 64'(1));
        check("bp.count", 64'(got_th.size()), 64'(2));
        if (got_th.size() == 2) begin
            check("bp.theta1", 64'(got_th[1]), 64'(48));
            check("bp.data1", 64'(got_d[1]), 64'(5678));
        end
        @(negedge clk);

        // len=0: done right after start, nothing read
        clear_q();
        start_scan(16'd45, 8'h00, 9'd0);
        check("len0.done", 64'(bus.done), 64'(1));
        check("len0.mem_rd", 64'(bus.mem_rd), 64'(0));
        @(negedge clk);
        check("len0.done_gone", 64'(bus.done), 64'(0));
        check("len0.busy", 64'(bus.busy), 64'(0));
        check("len0.reads", 64'(got_a.size()), 64'(0));

        // Starts while busy and coincident with done are ignored
        clear_q();
        dc = done_cnt;
        bus.out_ready = 1'b1;
        start_scan(16'd45, 8'h02, 9'd2);
        start_scan(16'd99, 8'h50, 9'd5);
        collect(100, fin);
        check("busy_start.finished", 64'(fin), 64'(1));
        bus.ref_angle = 16'd7;
        bus.base_addr = 8'h50;
        bus.len = 9'd3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("done_start.busy", 64'(bus.busy), 64'(0));
        @(negedge clk);
        check("done_start.still_idle", 64'(bus.busy), 64'(0));
        check("busy_start.count", 64'(got_th.size()), 64'(2));
        check("busy_start.reads", 64'(got_a.size()), 64'(2));
        if (got_th.size() > 0) check("busy_start.theta0", 64'(got_th[0]), 64'(47));
        check("busy_start.done_pulses", 64'(done_cnt - dc), 64'(1));

        // Reset in the middle of OUT
        bus.out_ready = 1'b0;
        start_scan(16'd45, 8'h02, 9'd2);
        wait_valid("rst_mid");
        dc = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid.theta", 64'(bus.theta), 64'(0));
        check("rst_mid.data_out", 64'(bus.data_out), 64'(0));
        check("rst_mid.out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_mid.busy", 64'(bus.busy), 64'(0));
        check("rst_mid.mem_rd", 64'(bus.mem_rd), 64'(0));
        check("rst_mid.mem_addr", 64'(bus.mem_addr), 64'(0));
        check("rst_mid.done", 64'(bus.done), 64'(0));
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mid.no_done", 64'(done_cnt - dc), 64'(0));
        check("rst_mid.idle", 64'(bus.busy), 64'(0));

        // Random scans against the list model
        for (int k = 0; k < 25; k++) begin
            do_scan($sformatf("rnd%0d", k), 16'($urandom), 8'($urandom),
                    9'($urandom_range(0, 24)), int'($urandom_range(25, 100)),
                    1'b0, 16'd0, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
